// File: rtl/dram_cmd_sequencer_if.sv
// Request/response bundle between the DRAM wrapper front end and the
// command sequencer.
//
// Handshake: the front end holds req_valid and all req_* fields stable
// until a cycle where req_valid && req_ready; that cycle transfers one
// request. Responses (rsp_valid for reads, rsp_wdone for writes) are
// single-cycle pulses with no backpressure. rsp_rdata holds its value
// until the next rsp_valid.
interface dram_cmd_sequencer_if #(
    parameter int ROW_W = 11,
    parameter int COL_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    logic [31:0]      req_wdata;
    logic [3:0]       req_wstrb;
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_wdone;

    modport master (
        output req_valid, req_op, req_row, req_col, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_wdone
    );

    modport slave (
        input  req_valid, req_op, req_row, req_col, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_wdone
    );
endinterface

// File: rtl/dram_cmd_sequencer.sv
// DRAM command/timing engine: turns one word request into PRE/ACT/CAS
// command cycles with tRP/tRCD/tCL spacing, keeps a row open between
// requests (open-page) and closes it after IDLE_PRE idle cycles.
// All DRAM pins are registered; a command is driven in the first cycle
// of its state, so pins change exactly on state entry.
module dram_cmd_sequencer #(
    parameter int ROW_W    = 11,
    parameter int COL_W    = 10,
    parameter int T_RCD    = 5,
    parameter int T_CL     = 5,
    parameter int T_RP     = 5,
    parameter int IDLE_PRE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_cmd_sequencer_if.slave  bus,
    output logic                 CSn,
    output logic                 RASn,
    output logic                 CASn,
    output logic [3:0]           WEn,
    output logic [10:0]          A,
    output logic [31:0]          D,
    input  logic [31:0]          Q,
    input  logic                 VALID,
    output logic [2:0]           dbg_state,
    output logic                 dbg_row_open,
    output logic                 dbg_rd_timeout
);

    localparam int A_W      = 11;
    localparam int CNT_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_MAX  = (CNT_MAX0 > T_CL + 8) ? CNT_MAX0 : T_CL + 8;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int IDLE_W   = $clog2(IDLE_PRE + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ACT  = 3'd2,
        S_CAS  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [IDLE_W-1:0] idle_cnt, idle_nx;
    logic              row_open, row_open_nx;
    logic [ROW_W-1:0]  open_row, open_row_nx;
    logic              pending, pending_nx;
    logic              rd_timeout, rd_to_nx;

    logic              ready_q;
    logic              rsp_valid_q, rsp_valid_nx;
    logic              rsp_wdone_q, rsp_wdone_nx;
    logic [31:0]       rsp_rdata_q, rsp_rdata_nx;

    logic              csn_nx, rasn_nx, casn_nx;
    logic [3:0]        wen_nx;
    logic [10:0]       a_nx;
    logic [31:0]       d_nx;

    logic [ROW_W-1:0]  lat_row;
    logic [COL_W-1:0]  lat_col;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_wstrb;
    logic              lat_wr;

    logic              accept, req_ok, req_hit;
    logic [ROW_W-1:0]  row_src;
    logic [COL_W-1:0]  col_src;
    logic [31:0]       wdata_src;
    logic [3:0]        wstrb_src;
    logic              wr_src;

    assign accept  = (state == S_IDLE) && ready_q && bus.req_valid;
    assign req_ok  = (bus.req_op == 2'b01) || (bus.req_op == 2'b10);
    assign req_hit = row_open && (bus.req_row == open_row);

    // In the accept cycle the latches are not yet loaded, so commands
    // issued straight out of IDLE take their fields from the bus.
    assign row_src   = accept ? bus.req_row   : lat_row;
    assign col_src   = accept ? bus.req_col   : lat_col;
    assign wdata_src = accept ? bus.req_wdata : lat_wdata;
    assign wstrb_src = accept ? bus.req_wstrb : lat_wstrb;
    assign wr_src    = accept ? (bus.req_op == 2'b10) : lat_wr;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_wdone = rsp_wdone_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign dbg_state      = state;
    assign dbg_row_open   = row_open;
    assign dbg_rd_timeout = rd_timeout;

    // Capture the request fields on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_row   <= '0;
            lat_col   <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_wr    <= 1'b0;
        end else if (accept) begin
            lat_row   <= bus.req_row;
            lat_col   <= bus.req_col;
            lat_wdata <= bus.req_wdata;
            lat_wstrb <= bus.req_wstrb;
            lat_wr    <= (bus.req_op == 2'b10);
        end
    end

    // Next-state, timing counters, open-row bookkeeping and responses.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + CNT_W'(1);
        idle_nx      = idle_cnt;
        row_open_nx  = row_open;
        open_row_nx  = open_row;
        pending_nx   = pending;
        rd_to_nx     = rd_timeout;
        rsp_valid_nx = 1'b0;
        rsp_wdone_nx = 1'b0;
        rsp_rdata_nx = rsp_rdata_q;
        unique case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (accept) begin
                    idle_nx = '0;
                    if (req_ok) begin
                        if (req_hit) begin
                            state_nx = S_CAS;
                        end else if (row_open) begin
                            state_nx   = S_PRE;
                            pending_nx = 1'b1;
                        end else begin
                            state_nx = S_ACT;
                        end
                    end
                end else if (!row_open) begin
                    idle_nx = '0;
                end else if (idle_cnt == IDLE_W'(IDLE_PRE - 1)) begin
                    idle_nx    = '0;
                    state_nx   = S_PRE;
                    pending_nx = 1'b0;
                end else begin
                    idle_nx = idle_cnt + IDLE_W'(1);
                end
            end
            S_PRE: begin
                if (cnt == CNT_W'(T_RP - 1)) begin
                    cnt_nx     = '0;
                    pending_nx = 1'b0;
                    state_nx   = pending ? S_ACT : S_IDLE;
                end
            end
            S_ACT: begin
                if (cnt == CNT_W'(T_RCD - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_CAS;
                end
            end
            S_CAS: begin
                cnt_nx   = '0;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (lat_wr) begin
                    if (cnt == CNT_W'(T_CL - 1)) begin
                        rsp_wdone_nx = 1'b1;
                        state_nx     = S_IDLE;
                    end
                end else if (VALID) begin
                    rsp_rdata_nx = Q;
                    rsp_valid_nx = 1'b1;
                    state_nx     = S_IDLE;
                end else if (cnt == CNT_W'(T_CL + 7)) begin
                    // DRAM never answered: complete with zero data.
                    rsp_rdata_nx = '0;
                    rsp_valid_nx = 1'b1;
                    rd_to_nx     = 1'b1;
                    state_nx     = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (state_nx == S_PRE && state != S_PRE) begin
            row_open_nx = 1'b0;
        end
        if (state_nx == S_ACT && state != S_ACT) begin
            row_open_nx = 1'b1;
            open_row_nx = row_src;
        end
    end

    // DRAM pin values: a command only in the first cycle of its state.
    always_comb begin
        csn_nx  = 1'b1;
        rasn_nx = 1'b1;
        casn_nx = 1'b1;
        wen_nx  = 4'hF;
        a_nx    = A;
        d_nx    = D;
        if (state_nx != state) begin
            case (state_nx)
                S_PRE: begin
                    csn_nx  = 1'b0;
                    rasn_nx = 1'b0;
                    wen_nx  = 4'h0;
                end
                S_ACT: begin
                    csn_nx  = 1'b0;
                    rasn_nx = 1'b0;
                    a_nx    = A_W'(row_src);
                end
                S_CAS: begin
                    csn_nx  = 1'b0;
                    casn_nx = 1'b0;
                    a_nx    = A_W'(col_src);
                    if (wr_src) begin
                        wen_nx = ~wstrb_src;
                        d_nx   = wdata_src;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idle_cnt    <= '0;
            row_open    <= 1'b0;
            open_row    <= '0;
            pending     <= 1'b0;
            rd_timeout  <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wdone_q <= 1'b0;
            rsp_rdata_q <= '0;
            CSn         <= 1'b1;
            RASn        <= 1'b1;
            CASn        <= 1'b1;
            WEn         <= 4'hF;
            A           <= '0;
            D           <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idle_cnt    <= idle_nx;
            row_open    <= row_open_nx;
            open_row    <= open_row_nx;
            pending     <= pending_nx;
            rd_timeout  <= rd_to_nx;
            ready_q     <= (state_nx == S_IDLE);
            rsp_valid_q <= rsp_valid_nx;
            rsp_wdone_q <= rsp_wdone_nx;
            rsp_rdata_q <= rsp_rdata_nx;
            CSn         <= csn_nx;
            RASn        <= rasn_nx;
            CASn        <= casn_nx;
            WEn         <= wen_nx;
            A           <= a_nx;
            D           <= d_nx;
        end
    end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Testbench for dram_cmd_sequencer: table of directed transactions with
// hand-computed command/response cycle offsets (relative to the accept
// cycle), plus hand-written sequences for auto-precharge, read timeout
// and reset during a read.
module tb_dram_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        CSn, RASn, CASn;
    logic [3:0]  WEn;
    logic [10:0] A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        VALID;
    logic [2:0]  dbg_state;
    logic        dbg_row_open;
    logic        dbg_rd_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_end = 0;

    dram_cmd_sequencer_if bus ();

    dram_cmd_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .CSn            (CSn),
        .RASn           (RASn),
        .CASn           (CASn),
        .WEn            (WEn),
        .A              (A),
        .D              (D),
        .Q              (Q),
        .VALID          (VALID),
        .dbg_state      (dbg_state),
        .dbg_row_open   (dbg_row_open),
        .dbg_rd_timeout (dbg_rd_timeout)
    );

    // Clock and cycle stamp.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Offsets are cycles after the accept cycle; -1 means "must not occur".
    typedef struct {
        logic [1:0]  op;
        logic [10:0] row;
        logic [9:0]  col;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        dram_valid;
        logic [31:0] dram_q;
        int          pre_off;
        int          act_off;
        int          cas_off;
        int          rsp_off;
        logic [3:0]  exp_wen;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [1:0] op, input logic [10:0] row,
                                input logic [9:0] col, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic dv,
                                input logic [31:0] q, input int pre, input int act,
                                input int cas, input int rsp, input logic [3:0] wen,
                                input logic [31:0] rdata);
        vec_t v;
        v.op = op; v.row = row; v.col = col; v.wdata = wdata; v.wstrb = wstrb;
        v.dram_valid = dv; v.dram_q = q;
        v.pre_off = pre; v.act_off = act; v.cas_off = cas; v.rsp_off = rsp;
        v.exp_wen = wen; v.exp_rdata = rdata;
        return v;
    endfunction

    task automatic check(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic wait_ready(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus.req_ready) seen = 1'b1;
        end
        if (!seen) check({nm, " ready_timeout"}, 0, 1);
    endtask

    // Drive one request, act as DRAM, record pin activity and compare.
    task automatic do_txn(input vec_t v, input string nm);
        int a, off, pre_c, act_c, cas_c, rsp_c, ncmd, kind, exp_n;
        logic [10:0] act_a, cas_a;
        logic [3:0]  cas_wen;
        logic [31:0] cas_d, got_rdata;
        logic        rdy1;
        bit          done, is_rw;
        wait_ready(nm);
        a = cyc;
        bus.req_op    = v.op;
        bus.req_row   = v.row;
        bus.req_col   = v.col;
        bus.req_wdata = v.wdata;
        bus.req_wstrb = v.wstrb;
        bus.req_valid = 1'b1;
        pre_c = -1; act_c = -1; cas_c = -1; rsp_c = -1; ncmd = 0; kind = 0;
        act_a = '0; cas_a = '0; cas_wen = '0; cas_d = '0; got_rdata = '0; rdy1 = 1'b0;
        done  = 1'b0;
        is_rw = (v.op == 2'b01) || (v.op == 2'b10);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            off = cyc - a;
            VALID = 1'b0;
            Q     = '0;
            if (off == 1) begin
                bus.req_valid = 1'b0;
                rdy1 = bus.req_ready;
            end
            if (!CSn) begin
                ncmd++;
                if (!RASn && WEn == 4'h0) begin
                    if (pre_c < 0) pre_c = off;
                end else if (!RASn) begin
                    if (act_c < 0) begin act_c = off; act_a = A; end
                end else if (!CASn) begin
                    if (cas_c < 0) begin cas_c = off; cas_a = A; cas_wen = WEn; cas_d = D; end
                end
            end
            if (v.dram_valid && cas_c >= 0 && off == cas_c + 5) begin
                VALID = 1'b1;
                Q     = v.dram_q;
            end
            if (bus.rsp_valid || bus.rsp_wdone) begin
                rsp_c     = off;
                kind      = bus.rsp_valid ? 1 : 2;
                got_rdata = bus.rsp_rdata;
                done      = 1'b1;
            end
            if (!is_rw && off == 6) done = 1'b1;
        end
        VALID = 1'b0;
        bus.req_valid = 1'b0;
        last_end = cyc;
        exp_n = (v.pre_off >= 0 ? 1 : 0) + (v.act_off >= 0 ? 1 : 0) + (v.cas_off >= 0 ? 1 : 0);
        check({nm, " pre_cycle"}, pre_c, v.pre_off);
        check({nm, " act_cycle"}, act_c, v.act_off);
        check({nm, " cas_cycle"}, cas_c, v.cas_off);
        check({nm, " rsp_cycle"}, rsp_c, v.rsp_off);
        check({nm, " cmd_count"}, ncmd, exp_n);
        check({nm, " ready_after_accept"}, rdy1, !is_rw);
        if (v.act_off >= 0) check({nm, " act_addr"}, act_a, v.row);
        if (v.cas_off >= 0) begin
            check({nm, " cas_addr"}, cas_a, {1'b0, v.col});
            check({nm, " cas_wen"}, cas_wen, v.exp_wen);
        end
        if (v.cas_off >= 0 && v.op == 2'b10) check({nm, " wdata"}, cas_d, v.wdata);
        if (v.rsp_off >= 0) check({nm, " rsp_kind"}, kind, v.op == 2'b01 ? 1 : 2);
        if (v.rsp_off >= 0 && v.op == 2'b01) check({nm, " rdata"}, got_rdata, v.exp_rdata);
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, " pins"}, {CSn, RASn, CASn, WEn, A, D}, {3'b111, 4'hF, 11'h0, 32'h0});
        check({nm, " rsp"}, {bus.req_ready, bus.rsp_valid, bus.rsp_wdone, bus.rsp_rdata}, 35'h0);
        check({nm, " internal"}, {dbg_state, dbg_row_open, dbg_rd_timeout}, 5'h0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, pre_cnt, pre_at, other, a;
        bit seen;
        vec_t v;
        rst = 1'b1;
        VALID = 1'b0;
        Q = '0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;

        vecs[0] = mk(2'b01, 11'h012, 10'h034, 32'h0, 4'h0, 1, 32'hDEADBEEF, -1, 1, 6, 12, 4'hF, 32'hDEADBEEF);
        vecs[1] = mk(2'b10, 11'h012, 10'h035, 32'h11223344, 4'b0101, 0, 32'h0, -1, -1, 1, 7, 4'b1010, 32'h0);
        vecs[2] = mk(2'b11, 11'h055, 10'h001, 32'hFFFFFFFF, 4'hF, 0, 32'h0, -1, -1, -1, -1, 4'hF, 32'h0);
        vecs[3] = mk(2'b00, 11'h012, 10'h034, 32'h0, 4'hF, 0, 32'h0, -1, -1, -1, -1, 4'hF, 32'h0);
        vecs[4] = mk(2'b01, 11'h7FF, 10'h3FF, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1, 6, 11, 17, 4'hF, 32'hCAFEF00D);
        vecs[5] = mk(2'b10, 11'h7FF, 10'h000, 32'hA5A5A5A5, 4'h0, 0, 32'h0, -1, -1, 1, 7, 4'hF, 32'h0);
        vecs[6] = mk(2'b10, 11'h7FF, 10'h2AA, 32'h0BADF00D, 4'hF, 0, 32'h0, -1, -1, 1, 7, 4'h0, 32'h0);
        vecs[7] = mk(2'b01, 11'h7FF, 10'h001, 32'h0, 4'h0, 1, 32'h12345678, -1, -1, 1, 7, 4'hF, 32'h12345678);

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        foreach (vecs[i]) do_txn(vecs[i], $sformatf("vec%0d", i));
        check("rd_timeout_clear", dbg_rd_timeout, 0);

        // Open row left idle: exactly one PRE after 16 idle cycles.
        p = last_end;
        pre_cnt = 0; pre_at = -1; other = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!CSn) begin
                if (!RASn && WEn == 4'h0) begin
                    pre_cnt++;
                    if (pre_at < 0) pre_at = cyc - p;
                end else begin
                    other++;
                end
            end
        end
        check("auto_pre_count", pre_cnt, 1);
        check("auto_pre_cycle", pre_at, 16);
        check("auto_pre_other_cmds", other, 0);
        check("auto_pre_row_open", dbg_row_open, 0);

        // Same row again must re-activate.
        v = mk(2'b01, 11'h7FF, 10'h010, 32'h0, 4'h0, 1, 32'h0F0F0F0F, -1, 1, 6, 12, 4'hF, 32'h0F0F0F0F);
        do_txn(v, "reopen");

        // Read the DRAM never answers: zero data at CAS+T_CL+9.
        v = mk(2'b01, 11'h7FF, 10'h005, 32'h0, 4'h0, 0, 32'h0, -1, -1, 1, 15, 4'hF, 32'h0);
        do_txn(v, "no_valid");
        check("rd_timeout_set", dbg_rd_timeout, 1);

        // Reset while a read is waiting for data.
        wait_ready("rst_wait");
        a = cyc;
        bus.req_op = 2'b01; bus.req_row = 11'h7FF; bus.req_col = 10'h007;
        bus.req_valid = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (!CSn && !CASn) seen = 1'b1;
        end
        check("rst_wait_cas_cycle", cyc - a, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst = 1'b0;

        // First request after reset takes the ACT path, no PRE.
        v = mk(2'b01, 11'h012, 10'h034, 32'h0, 4'h0, 1, 32'h55AA55AA, -1, 1, 6, 12, 4'hF, 32'h55AA55AA);
        do_txn(v, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
